// File: rtl/ysyx_23060187_wbu_pkg.sv
// Shared constants and FSM encodings for the EXU/WBU result handshake.
// Imported by the write-back unit and its register file.
package ysyx_23060187_wbu_pkg;
    localparam int WBU_XLEN   = 32;
    localparam int WBU_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } wbu_state_t;
endpackage

// File: rtl/ysyx_23060187_regfile.sv
// Integer register file: one write port, two combinational read ports, x0 hard-wired to zero.
// Write lands on the rising edge; reads see it from that edge on (no bypass).
module ysyx_23060187_regfile
    import ysyx_23060187_wbu_pkg::*;
#(
    parameter int XLEN   = WBU_XLEN,
    parameter int ADDR_W = WBU_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2
);
    localparam int NREGS = 1 << ADDR_W;

    logic [XLEN-1:0] r_regs [0:NREGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 is guarded on read as well so it stays zero regardless of array contents.
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
endmodule

// File: rtl/ysyx_23060187_wbu.sv
// Write-back unit: accepts one EXU result, commits it to the regfile, pulses completion, counts retirements.
// Latency 3 cycles per result (IDLE -> WRITE -> RESP); ready is low from acceptance until RESP ends.
module ysyx_23060187_wbu
    import ysyx_23060187_wbu_pkg::*;
#(
    parameter int XLEN   = WBU_XLEN,
    parameter int ADDR_W = WBU_ADDR_W,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXU_WBU_valid,
    output logic              WBU_EXU_ready,
    input  logic [31:0]       EXU_WBU_waddr,
    input  logic [XLEN-1:0]   EXU_WBU_wdata,
    input  logic              EXU_WBU_wen,
    output logic              WBU_EXU_valid,
    input  logic [ADDR_W-1:0] IDU_WBU_raddr1,
    input  logic [ADDR_W-1:0] IDU_WBU_raddr2,
    output logic [XLEN-1:0]   WBU_IDU_rdata1,
    output logic [XLEN-1:0]   WBU_IDU_rdata2,
    output logic [CNT_W-1:0]  WBU_instret
);
    wbu_state_t        r_state;
    logic              r_ready;
    logic              r_valid;
    logic [ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_wen;
    logic [CNT_W-1:0]  r_instret;
    logic              w_rf_wen;
    logic              w_unused_waddr_hi;

    assign w_unused_waddr_hi = ^EXU_WBU_waddr[31:ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_instret <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (EXU_WBU_valid) begin
                        r_waddr <= EXU_WBU_waddr[ADDR_W-1:0];
                        r_wdata <= EXU_WBU_wdata;
                        r_wen   <= EXU_WBU_wen;
                        r_state <= WRITE;
                        r_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state <= RESP;
                    r_valid <= 1'b1;
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_ready   <= 1'b1;
                    r_instret <= r_instret + CNT_W'(1);
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Commit happens on the edge that leaves WRITE, driven from the captured copy only.
    assign w_rf_wen = (r_state == WRITE) && r_wen;

    ysyx_23060187_regfile #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_wen    (w_rf_wen),
        .i_waddr  (r_waddr),
        .i_wdata  (r_wdata),
        .i_raddr1 (IDU_WBU_raddr1),
        .i_raddr2 (IDU_WBU_raddr2),
        .o_rdata1 (WBU_IDU_rdata1),
        .o_rdata2 (WBU_IDU_rdata2)
    );

    assign WBU_EXU_ready = r_ready;
    assign WBU_EXU_valid = r_valid;
    assign WBU_instret   = r_instret;
endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// Directed bench for the write-back unit; a second instance with a 4-bit counter exercises wrap.
module tb_ysyx_23060187_wbu;
    logic        clk;
    logic        rst;
    logic        ex_vld;
    logic [31:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_wen;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    logic        rdy, vld;
    logic [31:0] rdata1, rdata2;
    logic [63:0] instret;
    logic        rdy4, vld4;
    logic [31:0] rdata1_4, rdata2_4;
    logic [3:0]  instret4;

    int n_vec = 0;
    int n_err = 0;

    ysyx_23060187_wbu dut (
        .clk(clk), .rst(rst),
        .EXU_WBU_valid(ex_vld), .WBU_EXU_ready(rdy),
        .EXU_WBU_waddr(ex_waddr), .EXU_WBU_wdata(ex_wdata), .EXU_WBU_wen(ex_wen),
        .WBU_EXU_valid(vld),
        .IDU_WBU_raddr1(raddr1), .IDU_WBU_raddr2(raddr2),
        .WBU_IDU_rdata1(rdata1), .WBU_IDU_rdata2(rdata2),
        .WBU_instret(instret)
    );

    ysyx_23060187_wbu #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .EXU_WBU_valid(ex_vld), .WBU_EXU_ready(rdy4),
        .EXU_WBU_waddr(ex_waddr), .EXU_WBU_wdata(ex_wdata), .EXU_WBU_wen(ex_wen),
        .WBU_EXU_valid(vld4),
        .IDU_WBU_raddr1(raddr1), .IDU_WBU_raddr2(raddr2),
        .WBU_IDU_rdata1(rdata1_4), .WBU_IDU_rdata2(rdata2_4),
        .WBU_instret(instret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction at a negedge and return at the negedge after it retires.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic w);
        ex_vld = 1'b1; ex_waddr = a; ex_wdata = d; ex_wen = w;
        @(negedge clk);
        ex_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; ex_vld = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_wen = 1'b0;
        raddr1 = 5'd1; raddr2 = 5'd31;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", rdy); end
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", vld); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        n_vec++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata1, rdata2);
        end
    endtask

    task automatic test_write();
        raddr1 = 5'd5; raddr2 = 5'd0;
        ex_vld = 1'b1; ex_waddr = 32'd5; ex_wdata = 32'hDEADBEEF; ex_wen = 1'b1;
        @(negedge clk);  // in WRITE
        ex_vld = 1'b0; ex_wdata = 32'h0BADF00D;
        n_vec++; if (rdy !== 1'b0 || vld !== 1'b0) begin
            n_err++; $display("FAIL write_state_hs got=rdy%b/vld%b exp=rdy0/vld0", rdy, vld);
        end
        n_vec++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL write_old_read got=%h exp=0", rdata1); end
        @(negedge clk);  // in RESP
        n_vec++; if (vld !== 1'b1 || rdy !== 1'b0) begin
            n_err++; $display("FAIL write_pulse got=vld%b/rdy%b exp=vld1/rdy0", vld, rdy);
        end
        n_vec++; if (rdata1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_new_read got=%h exp=deadbeef", rdata1); end
        @(negedge clk);  // back in IDLE
        n_vec++; if (vld !== 1'b0 || rdy !== 1'b1) begin
            n_err++; $display("FAIL write_done got=vld%b/rdy%b exp=vld0/rdy1", vld, rdy);
        end
        n_vec++; if (instret !== 64'd1) begin n_err++; $display("FAIL write_instret got=%0d exp=1", instret); end
        n_vec++; if (rdata2 !== 32'd0) begin n_err++; $display("FAIL write_x0_port2 got=%h exp=0", rdata2); end
    endtask

    task automatic test_x0_write();
        int pulses = 0;
        raddr1 = 5'd0; raddr2 = 5'd5;
        ex_vld = 1'b1; ex_waddr = 32'd0; ex_wdata = 32'h12345678; ex_wen = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_vld = 1'b0;
            if (vld === 1'b1) pulses++;
        end
        n_vec++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL x0_read got=%h exp=0", rdata1); end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL x0_pulses got=%0d exp=1", pulses); end
        n_vec++; if (instret !== 64'd2) begin n_err++; $display("FAIL x0_instret got=%0d exp=2", instret); end
        n_vec++; if (rdata2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL x0_x5_kept got=%h exp=deadbeef", rdata2); end
    endtask

    task automatic test_no_wen();
        int pulses = 0;
        raddr1 = 5'd7;
        ex_vld = 1'b1; ex_waddr = 32'd7; ex_wdata = 32'hFFFFFFFF; ex_wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_vld = 1'b0;
            if (vld === 1'b1) pulses++;
        end
        n_vec++; if (rdata1 !== 32'd0) begin n_err++; $display("FAIL nowen_x7 got=%h exp=0", rdata1); end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL nowen_pulses got=%0d exp=1", pulses); end
        n_vec++; if (instret !== 64'd3) begin n_err++; $display("FAIL nowen_instret got=%0d exp=3", instret); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int pulses = 0;
        int pcyc [3] = '{0, 0, 0};
        for (int c = 0; c < 12; c++) begin
            if (rdy === 1'b1 && k < 3) begin
                ex_vld = 1'b1; ex_waddr = 32'(k + 1); ex_wdata = 32'(k + 1); ex_wen = 1'b1;
                k++;
            end else if (rdy === 1'b1) begin
                ex_vld = 1'b0;
            end else begin
                ex_waddr = 32'd13; ex_wdata = 32'h0000BAD0 + 32'(c); ex_wen = 1'b1;
            end
            @(negedge clk);
            if (vld === 1'b1) begin
                if (pulses < 3) pcyc[pulses] = c;
                pulses++;
            end
        end
        ex_vld = 1'b0;
        n_vec++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        n_vec++; if (pcyc[0] != 1 || pcyc[1] != 4 || pcyc[2] != 7) begin
            n_err++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=1,4,7", pcyc[0], pcyc[1], pcyc[2]);
        end
        raddr1 = 5'd1; raddr2 = 5'd2; #1;
        n_vec++; if (rdata1 !== 32'd1 || rdata2 !== 32'd2) begin
            n_err++; $display("FAIL b2b_x1x2 got=%h/%h exp=1/2", rdata1, rdata2);
        end
        raddr1 = 5'd3; raddr2 = 5'd13; #1;
        n_vec++; if (rdata1 !== 32'd3 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL b2b_x3x13 got=%h/%h exp=3/0", rdata1, rdata2);
        end
        n_vec++; if (instret !== 64'd6) begin n_err++; $display("FAIL b2b_instret got=%0d exp=6", instret); end
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        raddr1 = 5'd9; raddr2 = 5'd1;
        ex_vld = 1'b1; ex_waddr = 32'd9; ex_wdata = 32'h000000AA; ex_wen = 1'b1;
        @(negedge clk);  // in WRITE
        ex_vld = 1'b0;
        rst = 1'b0; #1;
        n_vec++; if (rdy !== 1'b1 || vld !== 1'b0 || instret !== 64'd0) begin
            n_err++; $display("FAIL rstmid_async got=rdy%b/vld%b/cnt%0d exp=rdy1/vld0/cnt0", rdy, vld, instret);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (vld === 1'b1) pulses++;
        end
        n_vec++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_err++; $display("FAIL rstmid_regs got=%h/%h exp=0/0", rdata1, rdata2);
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
        n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL rstmid_instret got=%0d exp=0", instret); end
    endtask

    task automatic test_wrap();
        raddr1 = 5'd20; raddr2 = 5'd0;
        for (int t = 0; t < 15; t++) run_txn(32'd20, 32'(t), 1'b1);
        n_vec++; if (instret4 !== 4'd15) begin n_err++; $display("FAIL wrap_pre got=%0d exp=15", instret4); end
        run_txn(32'hFFFF_FFF4, 32'h0000_0099, 1'b1);
        n_vec++; if (instret4 !== 4'd0) begin n_err++; $display("FAIL wrap_cnt4 got=%0d exp=0", instret4); end
        n_vec++; if (instret !== 64'd16) begin n_err++; $display("FAIL wrap_cnt64 got=%0d exp=16", instret); end
        // Upper address bits ignored: 0xFFFFFFF4 lands in x20.
        n_vec++; if (rdata1 !== 32'h99) begin n_err++; $display("FAIL wrap_addr_hi got=%h exp=99", rdata1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_x0_write();
        test_no_wen();
        test_back_to_back();
        test_reset_mid_write();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1);
    end
endmodule
